// File: rtl/ring_counter_pkg.sv
// Shared constants for the ring / Johnson counter family.
package ring_counter_pkg;

  // Counter flavour selected by the mode input.
  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  // Shift direction selected by the dir input.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/ring_pattern_check.sv
// Combinational legality check for a ring (one-hot) or Johnson pattern.
module ring_pattern_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] pattern,
  input  logic             mode,
  output logic             legal
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] ones;
  logic [CW-1:0] edges;

  // Count set bits and adjacent-bit transitions, then judge against the mode.
  always_comb begin
    ones  = {CW{1'b0}};
    edges = {CW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CW'(pattern[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + CW'(pattern[i] ^ pattern[i+1]);
    end
    case (mode)
      MODE_RING:    legal = (ones == CW'(1));
      MODE_JOHNSON: legal = (edges <= CW'(1));
      default:      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ring_johnson_counter.sv
// Parametrised ring / Johnson counter with checked load, repair and wrap count.
module ring_johnson_counter
  import ring_counter_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CNT_W        = 8,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             err,
  output logic [CNT_W-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0] INIT_R = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] INIT_J = {WIDTH{1'b0}};

  logic             mode_r;
  logic             mode_next;
  logic             q_legal;
  logic             load_legal;
  logic [WIDTH-1:0] init;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic             err_next;

  ring_pattern_check #(.WIDTH(WIDTH)) u_q_check (
    .pattern (q),
    .mode    (mode_r),
    .legal   (q_legal)
  );

  ring_pattern_check #(.WIDTH(WIDTH)) u_load_check (
    .pattern (load_val),
    .mode    (mode_r),
    .legal   (load_legal)
  );

  // Start pattern of the mode currently in force.
  always_comb begin
    if (mode_r == MODE_JOHNSON) begin
      init = INIT_J;
    end else begin
      init = INIT_R;
    end
  end

  // One shift step of the current state for the active mode and direction.
  always_comb begin
    case ({mode_r, dir})
      {MODE_RING,    DIR_UP}:   shifted = {q[WIDTH-2:0], q[WIDTH-1]};
      {MODE_RING,    DIR_DOWN}: shifted = {q[0], q[WIDTH-1:1]};
      {MODE_JOHNSON, DIR_UP}:   shifted = {q[WIDTH-2:0], ~q[WIDTH-1]};
      {MODE_JOHNSON, DIR_DOWN}: shifted = {~q[0], q[WIDTH-1:1]};
      default:                  shifted = q;
    endcase
  end

  // Prioritised next-state: mode change, load, repair, shift, hold.
  always_comb begin
    q_next    = q;
    mode_next = mode_r;
    tc_next   = 1'b0;
    err_next  = 1'b0;
    if (mode != mode_r) begin
      mode_next = mode;
      q_next    = (mode == MODE_JOHNSON) ? INIT_J : INIT_R;
    end else if (load) begin
      if (load_legal) begin
        q_next = load_val;
      end else begin
        q_next   = init;
        err_next = 1'b1;
      end
    end else if (!q_legal) begin
      err_next = 1'b1;
      if (SELF_CORRECT) begin
        q_next = init;
      end else begin
        q_next = q;
      end
    end else if (en) begin
      q_next  = shifted;
      tc_next = (shifted == init);
    end else begin
      q_next = q;
    end
  end

  // State, flags and wrap counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= INIT_R;
      mode_r   <= MODE_RING;
      tc       <= 1'b0;
      err      <= 1'b0;
      wrap_cnt <= {CNT_W{1'b0}};
    end else begin
      q      <= q_next;
      mode_r <= mode_next;
      tc     <= tc_next;
      err    <= err_next;
      if (tc_next) begin
        wrap_cnt <= wrap_cnt + CNT_W'(1);
      end else begin
        wrap_cnt <= wrap_cnt;
      end
    end
  end

endmodule

// File: doc/ring_johnson_counter.md
Name: ring_johnson_counter

Overview:
- Parametrised successor to the team's fixed 4-bit ring counter.
- Supports any WIDTH, ring (one-hot) or Johnson (twisted-ring) mode, up/down direction, count enable, and checked parallel load.
- Repairs illegal states, flags wrap-around, and counts wraps.
- Used as a sequence or phase generator for one-hot strobes and time-slot selects.

Parameters:
- WIDTH, 4, number of state bits; legal range 2..32.
- CNT_W, 8, width of the wrap counter.
- SELF_CORRECT, 1, when 1, illegal states are repaired on the next edge; when 0, they are only flagged.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  shift enable.
- dir  in  1  0 = shift toward MSB (q[i] <= q[i-1]); 1 = shift toward LSB.
- mode  in  1  0 = ring; 1 = Johnson.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  counter state (registered).
- tc  out  1  registered wrap pulse.
- err  out  1  registered one-cycle pulse: rejected load, or illegal state detected.
- wrap_cnt  out  CNT_W  number of wraps, modulo 2^CNT_W.

Behaviour:
- Init patterns: ring INIT_R = 1 << (WIDTH-1); Johnson INIT_J = all zeros. INIT = the init pattern of mode_r.
- Reset (asynchronous, immediate):
  - q = INIT_R, mode_r = 0.
  - tc = 0, err = 0, wrap_cnt = 0.
- Legality:
  - Ring: exactly one bit of q is set.
  - Johnson: at most one index i in 0..WIDTH-2 with q[i] != q[i+1], i.e. 2*WIDTH legal states.
- Shift rules:
  - Ring up: {q[W-2:0], q[W-1]}. Ring down: {q[0], q[W-1:1]}.
  - Johnson up: {q[W-2:0], ~q[W-1]}. Johnson down: {~q[0], q[W-1:1]}.
- Priority each rising edge (first match wins):
  1. Mode change (mode != mode_r): mode_r <= mode; q <= new mode's init pattern; tc = 0; err = 0.
  2. load=1, load_val legal for mode_r: q <= load_val; err = 0. Applies regardless of en.
  3. load=1, load_val illegal: q <= INIT; err = 1 for one cycle.
  4. q illegal: q <= INIT if SELF_CORRECT, else q holds; err = 1 for one cycle. err repeats every cycle while q stays illegal.
  5. en=1: q <= shifted value.
  6. Otherwise q holds.
- Wrap flag and counter:
  - tc = 1 in the cycle after a case-5 shift whose result equals INIT; otherwise 0.
  - wrap_cnt increments on the same edge tc rises; rolls over from 2^CNT_W-1 to 0.
  - Load, correction and mode change never assert tc or increment wrap_cnt, even when the resulting q equals INIT.
- Period: ring WIDTH cycles; Johnson 2*WIDTH cycles. Direction change mid-sequence takes effect on the next enabled edge with no glitch state.
- Reset mid-operation: async clear of all outputs to reset values, independent of clk; after rst deasserts, the first enabled edge shifts from INIT_R.

Decomposition:
- Package ring_counter_pkg:
  - Mode constants MODE_RING = 1'b0, MODE_JOHNSON = 1'b1.
  - Direction constants DIR_UP = 1'b0, DIR_DOWN = 1'b1.
- Sub-module ring_pattern_check (parameter WIDTH): purely combinational.
  - Inputs: pattern, mode. Output: legal.
  - Instantiated twice: once on q, once on load_val.

Test Plan (WIDTH=4):
- Ring up after reset, en=1, dir=0, mode=0 -> q = 1000, 0001, 0010, 0100, 1000; tc=1 on the cycle q returns to 1000; wrap_cnt = 1; en=0 then holds q.
- Ring down from reset, dir=1 -> q = 0100, 0010, 0001, 1000; tc on 4th step. Toggle dir mid-run at q=0010 -> next value 0100.
- Switch mode=1 at q=0100 -> next q = 0000, tc=0. en=1, dir=0 -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; tc on 8th step.
- Ring load 0010 -> q=0010, err=0. Load 0110 -> q=1000, err=1 for one cycle. Load with en=1 takes priority over shift.
- Force q=0101 in ring mode, en=0 -> q=1000, err=1, tc=0. Repeat with SELF_CORRECT=0 -> q stays 0101, err=1 every cycle.
- Assert rst between edges mid-run with wrap_cnt=3 -> q=1000, wrap_cnt=0, tc=0, err=0 immediately without a clock edge. With CNT_W=2 run 4 wraps -> wrap_cnt rolls 3 -> 0.
